project_pwm_peripheral_deadband_pair: RTL

Complementary dead-band generator for one PWM channel. Converts a single PWM stream into a high-side/low-side pair with independently programmable rising-edge delay (RED) and falling-edge delay (FED), both parametrised in width. Input pulses shorter than the active delay are suppressed. It sits between the PWM comparator stage and the pad drivers and replaces the single-output dead-band block.

---
 rtl/project_pwm_peripheral_pkg.sv | 25 ++
 rtl/project_pwm_peripheral_dt_counter.sv | 30 +++
 rtl/project_pwm_peripheral_deadband_pair.sv | 140 ++++++++++++++
 3 files changed

// File: rtl/project_pwm_peripheral_pkg.sv
// Shared state encodings for the dead-band pair FSM and future multi-channel wrappers.
// Latency: n/a (definitions only).
// Backpressure: n/a.
package project_pwm_peripheral_pkg;

    localparam logic [2:0] ST_OFF      = 3'd0;
    localparam logic [2:0] ST_LOW      = 3'd1;
    localparam logic [2:0] ST_RED_WAIT = 3'd2;
    localparam logic [2:0] ST_HIGH     = 3'd3;
    localparam logic [2:0] ST_FED_WAIT = 3'd4;

    typedef enum logic [2:0] {
        S_OFF      = ST_OFF,
        S_LOW      = ST_LOW,
        S_RED_WAIT = ST_RED_WAIT,
        S_HIGH     = ST_HIGH,
        S_FED_WAIT = ST_FED_WAIT
    } state_e;

    // Both switches held off while a dead-time interval runs.
    function automatic logic is_dead(input state_e s);
        return (s == S_RED_WAIT) || (s == S_FED_WAIT);
    endfunction

endpackage

// File: rtl/project_pwm_peripheral_dt_counter.sv
// Dead-time down-counter: load has priority, otherwise decrement when enabled.
// Latency: load/decrement take effect on the next clock edge; cnt_one is combinational from the count.
// Backpressure: none; the count saturates at zero so it can never wrap.
module project_pwm_peripheral_dt_counter #(
    parameter int DW = 4
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          load,
    input  logic [DW-1:0] load_val,
    input  logic          dec,
    output logic          cnt_one
);

    logic [DW-1:0] cnt;

    // Count register: reset to zero, load on strobe, otherwise count down without wrapping.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= load_val;
        end else if (dec && (cnt != '0)) begin
            cnt <= cnt - 1'b1;
        end
    end

    assign cnt_one = (cnt == DW'(1));

endmodule

// File: rtl/project_pwm_peripheral_deadband_pair.sv
// Complementary high/low drive pair with independent rising/falling dead time and short-pulse suppression.
// Latency: one cycle from i_pwm to outputs; dead time adds RED/FED cycles. Optional macro: DEADBAND_SHADOW_EN.
// Backpressure: none; input pulses shorter than the active dead time are swallowed and flagged on o_swallow.
module project_pwm_peripheral_deadband_pair
    import project_pwm_peripheral_pkg::*;
#(
    parameter int DW = 4
) (
    input  logic          i_clk,
    input  logic          i_reset,
    input  logic          i_pwm,
    input  logic [DW-1:0] i_red,
    input  logic [DW-1:0] i_fed,
`ifdef DEADBAND_SHADOW_EN
    input  logic          i_update,
`endif
    output logic          o_pwm_h,
    output logic          o_pwm_l,
    output logic          o_dead,
    output logic          o_swallow
);

    logic [DW-1:0] red_eff;
    logic [DW-1:0] fed_eff;

`ifdef DEADBAND_SHADOW_EN
    logic [DW-1:0] red_shadow;
    logic [DW-1:0] fed_shadow;

    // Shadow delay registers so software can retune both delays atomically.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            red_shadow <= '0;
            fed_shadow <= '0;
        end else if (i_update) begin
            red_shadow <= i_red;
            fed_shadow <= i_fed;
        end
    end

    assign red_eff = red_shadow;
    assign fed_eff = fed_shadow;
`else
    assign red_eff = i_red;
    assign fed_eff = i_fed;
`endif

    state_e        state_q;
    state_e        state_d;
    logic          cnt_load;
    logic [DW-1:0] cnt_val;
    logic          cnt_dec;
    logic          cnt_one;
    logic          swallow_d;

    project_pwm_peripheral_dt_counter #(
        .DW (DW)
    ) u_dt_counter (
        .clk      (i_clk),
        .reset    (i_reset),
        .load     (cnt_load),
        .load_val (cnt_val),
        .dec      (cnt_dec),
        .cnt_one  (cnt_one)
    );

    // Next-state logic; delays are captured into the counter only when a wait state is entered.
    always_comb begin
        state_d   = state_q;
        cnt_load  = 1'b0;
        cnt_val   = red_eff;
        cnt_dec   = 1'b0;
        swallow_d = 1'b0;
        case (state_q)
            S_OFF, S_LOW: begin
                if (i_pwm) begin
                    if (red_eff == '0) begin
                        state_d = S_HIGH;
                    end else begin
                        state_d  = S_RED_WAIT;
                        cnt_load = 1'b1;
                        cnt_val  = red_eff;
                    end
                end else begin
                    state_d = S_LOW;
                end
            end
            S_RED_WAIT: begin
                cnt_dec = 1'b1;
                if (!i_pwm) begin
                    state_d   = S_LOW;
                    swallow_d = 1'b1;
                end else if (cnt_one) begin
                    state_d = S_HIGH;
                end
            end
            S_HIGH: begin
                if (!i_pwm) begin
                    if (fed_eff == '0) begin
                        state_d = S_LOW;
                    end else begin
                        state_d  = S_FED_WAIT;
                        cnt_load = 1'b1;
                        cnt_val  = fed_eff;
                    end
                end
            end
            S_FED_WAIT: begin
                cnt_dec = 1'b1;
                if (i_pwm) begin
                    state_d   = S_HIGH;
                    swallow_d = 1'b1;
                end else if (cnt_one) begin
                    state_d = S_LOW;
                end
            end
            default: begin
                state_d = S_OFF;
            end
        endcase
    end

    // State and output registers; outputs decoded from next state so they switch with the state register.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state_q   <= S_OFF;
            o_pwm_h   <= 1'b0;
            o_pwm_l   <= 1'b0;
            o_dead    <= 1'b0;
            o_swallow <= 1'b0;
        end else begin
            state_q   <= state_d;
            o_pwm_h   <= (state_d == S_HIGH);
            o_pwm_l   <= (state_d == S_LOW);
            o_dead    <= is_dead(state_d);
            o_swallow <= swallow_d;
        end
    end

endmodule
